ins_fetch: RTL and testbench

- Front-end fetch stage. Owns the PC and looks up the instruction cache every cycle.
- On a miss it fetches the 32-bit word through the memory controller, writes it into the ICache, and enqueues the {pc, inst} pair into an internal instruction queue.
- The queue feeds the decoder/issue stage.
- Pipeline clear from the ROB flushes the queue and redirects the PC.

---
 rtl/ins_fetch_pkg.sv | 21 ++
 rtl/ins_fetch_if.sv | 35 +++
 rtl/ins_queue.sv | 72 +++++++
 rtl/ins_fetch.sv | 142 ++++++++++++++
 tb/tb_ins_fetch.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Holds widths, fetch-state encodings and the queue entry layout.
package ins_fetch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/ins_fetch_if.sv
// Bus bundle between the fetch stage and the ICache, memory controller
// and decoder.
interface ins_fetch_if;
    import ins_fetch_pkg::*;

    logic [DATA_WIDTH-1:0] ic_addr;
    logic                  ic_hit;
    logic [INST_WIDTH-1:0] ic_inst;
    logic                  ic_wr_en;
    logic [DATA_WIDTH-1:0] ic_wr_addr;
    logic [INST_WIDTH-1:0] ic_wr_inst;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_done;
    logic [INST_WIDTH-1:0] mem_data;
    logic                  out_valid;
    logic [INST_WIDTH-1:0] out_inst;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_ready;

    modport master (
        output ic_addr, ic_wr_en, ic_wr_addr, ic_wr_inst,
        output mem_req, mem_addr,
        output out_valid, out_inst, out_pc,
        input  ic_hit, ic_inst, mem_done, mem_data, out_ready
    );

    modport slave (
        input  ic_addr, ic_wr_en, ic_wr_addr, ic_wr_inst,
        input  mem_req, mem_addr,
        input  out_valid, out_inst, out_pc,
        output ic_hit, ic_inst, mem_done, mem_data, out_ready
    );

endinterface

// File: rtl/ins_queue.sv
// Circular instruction queue of {pc, inst} entries.
// Flush wins over push and pop; rdy low freezes everything.
module ins_queue
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_pc,
    input  logic [INST_WIDTH-1:0] push_inst,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_pc,
    output logic [INST_WIDTH-1:0] head_inst
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    iq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_en;
    logic              pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = rdy & push & ~full & ~flush;
    assign pop_en  = rdy & pop & ~empty & ~flush;

    assign head_pc   = mem_q[head_q].pc;
    assign head_inst = mem_q[head_q].inst;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) tail_d = tail_q + AW'(1);
            if (pop_en)  head_d = head_q + AW'(1);
            if (push_en && !pop_en) count_d = count_q + CW'(1);
            if (pop_en && !push_en) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[tail_q] <= '{pc: push_pc, inst: push_inst};
    end

endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: owns the PC, looks up the ICache, services misses
// through memory and feeds the instruction queue.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int                    QUEUE_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear_flag,
    input  logic [DATA_WIDTH-1:0] clear_pc,
    ins_fetch_if.master           bus
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  ic_wr_en_q, ic_wr_en_d;
    logic [DATA_WIDTH-1:0] ic_wr_addr_q, ic_wr_addr_d;
    logic [INST_WIDTH-1:0] ic_wr_inst_q, ic_wr_inst_d;

    logic                  q_push;
    logic [DATA_WIDTH-1:0] q_push_pc;
    logic [INST_WIDTH-1:0] q_push_inst;
    logic                  q_full;
    logic                  q_empty;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ic_wr_en_d   = 1'b0;
        ic_wr_addr_d = ic_wr_addr_q;
        ic_wr_inst_d = ic_wr_inst_q;
        q_push       = 1'b0;
        q_push_pc    = pc_q;
        q_push_inst  = bus.ic_inst;
        if (clear_flag) begin
            pc_d = clear_pc;
            if (state_q != FETCH) begin
                // Outstanding miss: fill the cache but never enqueue it.
                if (bus.mem_done) begin
                    state_d      = FETCH;
                    mem_req_d    = 1'b0;
                    ic_wr_en_d   = 1'b1;
                    ic_wr_addr_d = mem_addr_q;
                    ic_wr_inst_d = bus.mem_data;
                end else begin
                    state_d = DRAIN;
                end
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (!q_full && bus.ic_hit) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + PC_INC;
                    end else if (!q_full) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        mem_req_d    = 1'b0;
                        ic_wr_en_d   = 1'b1;
                        ic_wr_addr_d = mem_addr_q;
                        ic_wr_inst_d = bus.mem_data;
                        q_push       = 1'b1;
                        q_push_pc    = mem_addr_q;
                        q_push_inst  = bus.mem_data;
                        pc_d         = pc_q + PC_INC;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.mem_done) begin
                        mem_req_d    = 1'b0;
                        ic_wr_en_d   = 1'b1;
                        ic_wr_addr_d = mem_addr_q;
                        ic_wr_inst_d = bus.mem_data;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ic_wr_en_q   <= 1'b0;
            ic_wr_addr_q <= '0;
            ic_wr_inst_q <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ic_wr_en_q   <= ic_wr_en_d;
            ic_wr_addr_q <= ic_wr_addr_d;
            ic_wr_inst_q <= ic_wr_inst_d;
        end else begin
            ic_wr_en_q <= 1'b0;
        end
    end

    ins_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .push     (q_push),
        .push_pc  (q_push_pc),
        .push_inst(q_push_inst),
        .pop      (bus.out_ready),
        .flush    (clear_flag),
        .full     (q_full),
        .empty    (q_empty),
        .head_pc  (bus.out_pc),
        .head_inst(bus.out_inst)
    );

    assign bus.ic_addr    = pc_q;
    assign bus.ic_wr_en   = ic_wr_en_q;
    assign bus.ic_wr_addr = ic_wr_addr_q;
    assign bus.ic_wr_inst = ic_wr_inst_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.out_valid  = ~q_empty;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: hits, misses, flush, stall, wrap and
// asynchronous reset, with hand-computed expectations.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear_flag = 1'b0;
    logic [31:0] clear_pc = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    ins_fetch_if bus();

    ins_fetch #(
        .QUEUE_DEPTH(16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear_flag(clear_flag),
        .clear_pc  (clear_pc),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_chk(input logic [31:0] a, input logic [31:0] d);
        chk("wr_en", 32'(bus.ic_wr_en), 32'd1);
        chk("wr_addr", bus.ic_wr_addr, a);
        chk("wr_inst", bus.ic_wr_inst, d);
        chk("fill_req", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        bus.ic_hit    = 1'b1;
        bus.ic_inst   = 32'h0000_0013;
        bus.mem_done  = 1'b0;
        bus.mem_data  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'd0);
        chk("rst_wr_en", 32'(bus.ic_wr_en), 32'd0);
        chk("rst_wr_addr", bus.ic_wr_addr, 32'd0);
        chk("rst_wr_inst", bus.ic_wr_inst, 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", bus.ic_addr, 32'd0);
        rst = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            step();
            chk("fill_pc", bus.ic_addr, 32'(4 * k));
        end
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_head_pc", bus.out_pc, 32'h0);
        chk("full_head_inst", bus.out_inst, 32'h13);
        step();
        step();
        chk("full_stall", bus.ic_addr, 32'h40);

        // Pop from full: first pop frees a slot, pushes resume next cycle.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pop_pc", bus.out_pc, 32'(4 * k));
            step();
            chk("pop_fetch_pc", bus.ic_addr, 32'h40 + 32'(4 * k));
        end

        // Drain 15 entries across the pointer wrap while a miss goes out.
        bus.ic_hit = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("drain_pc", bus.out_pc, 32'h10 + 32'(4 * k));
            step();
            if (k == 0) begin
                chk("miss_req", 32'(bus.mem_req), 32'd1);
                chk("miss_addr", bus.mem_addr, 32'h4C);
            end
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        bus.mem_done = 1'b1;
        bus.mem_data = 32'hDEAD_BEEF;
        step();
        bus.mem_done = 1'b0;
        fill_chk(32'h4C, 32'hDEAD_BEEF);
        chk("miss_q_valid", 32'(bus.out_valid), 32'd1);
        chk("miss_q_pc", bus.out_pc, 32'h4C);
        chk("miss_q_inst", bus.out_inst, 32'hDEAD_BEEF);
        chk("miss_next_pc", bus.ic_addr, 32'h50);
        step();
        chk("wr_pulse", 32'(bus.ic_wr_en), 32'd0);
        chk("miss2_req", 32'(bus.mem_req), 32'd1);
        chk("miss2_addr", bus.mem_addr, 32'h50);

        clear_flag = 1'b1;
        clear_pc   = 32'h2000;
        step();
        clear_flag = 1'b0;
        chk("clr_empty", 32'(bus.out_valid), 32'd0);
        chk("clr_pc", bus.ic_addr, 32'h2000);
        chk("clr_req", 32'(bus.mem_req), 32'd1);
        step();
        step();
        chk("drain_hold", 32'(bus.mem_req), 32'd1);
        chk("drain_pc_hold", bus.ic_addr, 32'h2000);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h1111_2222;
        step();
        bus.mem_done = 1'b0;
        fill_chk(32'h50, 32'h1111_2222);
        chk("drain_no_push", 32'(bus.out_valid), 32'd0);
        chk("drain_pc_keep", bus.ic_addr, 32'h2000);
        bus.ic_hit  = 1'b1;
        bus.ic_inst = 32'h33;
        step();
        chk("redir_pc", bus.out_pc, 32'h2000);
        chk("redir_inst", bus.out_inst, 32'h33);
        chk("redir_next", bus.ic_addr, 32'h2004);

        bus.ic_hit = 1'b0;
        step();
        chk("stall_req0", bus.mem_addr, 32'h2004);
        rdy          = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h0000_0BAD;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_req", 32'(bus.mem_req), 32'd1);
            chk("stall_maddr", bus.mem_addr, 32'h2004);
            chk("stall_pc", bus.ic_addr, 32'h2004);
            chk("stall_wr", 32'(bus.ic_wr_en), 32'd0);
        end
        rdy          = 1'b1;
        bus.mem_done = 1'b0;
        step();
        chk("resume_wait", 32'(bus.mem_req), 32'd1);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h55AA_55AA;
        step();
        bus.mem_done = 1'b0;
        fill_chk(32'h2004, 32'h55AA_55AA);
        chk("resume_pc", bus.ic_addr, 32'h2008);

        clear_flag  = 1'b1;
        clear_pc    = 32'hFFFF_FFFC;
        bus.ic_hit  = 1'b1;
        bus.ic_inst = 32'h44;
        step();
        clear_flag = 1'b0;
        chk("clr2_empty", 32'(bus.out_valid), 32'd0);
        step();
        chk("wrap_pc", bus.ic_addr, 32'h0);
        chk("wrap_head", bus.out_pc, 32'hFFFF_FFFC);

        bus.ic_hit = 1'b0;
        step();
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(bus.mem_req), 32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        bus.ic_hit  = 1'b1;
        bus.ic_inst = 32'h77;
        step();
        rst = 1'b1;
        step();
        chk("restart_head", bus.out_pc, 32'h0);
        chk("restart_inst", bus.out_inst, 32'h77);
        chk("restart_pc", bus.ic_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
